// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // A PC is usable when it is word aligned and inside the instruction memory.
   function automatic logic pc_ok(input logic [31:0] pc, input int unsigned mem_words);
      logic [31:0] limit;
      limit = 32'(mem_words) << 2;
      return (pc[1:0] == 2'b00) && (pc < limit);
   endfunction

endpackage

// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational instruction
// memory and registers each returned word into a one-entry fetch buffer offered
// downstream. Handles start/halt, redirects and PC faults.
//
// Handshake: a packet transfers on every rising edge where if_valid && if_ready.
// if_valid never drops without a transfer except on redirect squash, fault or
// reset; if_pc/if_instr are stable while if_valid && !if_ready.
module instruction_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 128,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt_req,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic [1:0]  state,
   output logic        fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_count
);
   import fetch_pkg::*;

   fetch_state_e state_q, state_n;
   logic [31:0]  pc_q, pc_n;
   logic         valid_q, valid_n;
   logic [31:0]  if_pc_q, if_pc_n;
   logic [31:0]  instr_q, instr_n;
   logic         fault_q, fault_n;
   logic [31:0]  fault_pc_q, fault_pc_n;
   logic [31:0]  count_q, count_n;
   logic         handshake;
   logic         slot_free;

   assign handshake = valid_q && if_ready;
   assign slot_free = !valid_q || if_ready;

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         if_pc_q    <= 32'h0;
         instr_q    <= NOP_INSTR;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0;
         count_q    <= 32'h0;
      end else begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         valid_q    <= valid_n;
         if_pc_q    <= if_pc_n;
         instr_q    <= instr_n;
         fault_q    <= fault_n;
         fault_pc_q <= fault_pc_n;
         count_q    <= count_n;
      end
   end

   // Next state: redirect first (may fault), then per-state sequencing and capture.
   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      valid_n    = valid_q && !if_ready;
      if_pc_n    = if_pc_q;
      instr_n    = instr_q;
      fault_n    = fault_q;
      fault_pc_n = fault_pc_q;
      count_n    = handshake ? count_q + 32'd1 : count_q;

      if (state_q != FAULT) begin
         if (redirect_valid) begin
            valid_n = 1'b0;
            if (pc_ok(redirect_pc, MEM_WORDS)) begin
               pc_n = redirect_pc;
            end else begin
               fault_n    = 1'b1;
               fault_pc_n = redirect_pc;
               state_n    = FAULT;
            end
         end

         if (state_n != FAULT) begin
            case (state_q)
               IDLE: begin
                  if (start) state_n = RUN;
               end
               RUN: begin
                  if (halt_req) begin
                     state_n = DRAIN;
                  end else if (!redirect_valid && slot_free) begin
                     if (pc_ok(pc_q, MEM_WORDS)) begin
                        if_pc_n = pc_q;
                        instr_n = imem_instruction;
                        valid_n = 1'b1;
                        pc_n    = pc_q + 32'd4;
                     end else begin
                        fault_n    = 1'b1;
                        fault_pc_n = pc_q;
                        valid_n    = 1'b0;
                        state_n    = FAULT;
                     end
                  end
               end
               DRAIN: begin
                  if (slot_free) state_n = IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign imem_address = pc_q;
   assign if_valid     = valid_q;
   assign if_pc        = if_pc_q;
   assign if_instr     = valid_q ? instr_q : NOP_INSTR;
   assign state        = state_q;
   assign fault        = fault_q;
   assign fault_pc     = fault_pc_q;
   assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed bench for instruction_fetch_ctrl with a behavioural instruction memory.
module tb_instruction_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [1:0]  state;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [0:127];

   instruction_fetch_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .halt_req         (halt_req),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .if_valid         (if_valid),
      .if_ready         (if_ready),
      .if_pc            (if_pc),
      .if_instr         (if_instr),
      .state            (state),
      .fault            (fault),
      .fault_pc         (fault_pc),
      .fetch_count      (fetch_count)
   );

   // Clock
   always #5 clk = ~clk;

   // Combinational instruction memory
   assign imem_instruction = (imem_address < 32'd512) ? mem[imem_address[8:2]] : NOP;

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      step();
      n_cmp++; if (state !== 2'd0)        begin n_bad++; $display("FAIL rst_state got %0d want 0", state); end
      n_cmp++; if (if_valid !== 1'b0)     begin n_bad++; $display("FAIL rst_valid got %b want 0", if_valid); end
      n_cmp++; if (if_pc !== 32'h0)       begin n_bad++; $display("FAIL rst_if_pc got %h want 0", if_pc); end
      n_cmp++; if (if_instr !== NOP)      begin n_bad++; $display("FAIL rst_instr got %h want %h", if_instr, NOP); end
      n_cmp++; if (fault !== 1'b0)        begin n_bad++; $display("FAIL rst_fault got %b want 0", fault); end
      n_cmp++; if (fault_pc !== 32'h0)    begin n_bad++; $display("FAIL rst_fault_pc got %h want 0", fault_pc); end
      n_cmp++; if (fetch_count !== 32'h0) begin n_bad++; $display("FAIL rst_count got %h want 0", fetch_count); end
      n_cmp++; if (imem_address !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", imem_address); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [0:3];
      logic [31:0] exp_in [0:3];
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
      exp_in[0] = 32'h00000013; exp_in[1] = 32'h00400093;
      exp_in[2] = 32'h00C00113; exp_in[3] = 32'h002081B3;
      if_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++; if (state !== 2'd1)    begin n_bad++; $display("FAIL seq_run got %0d want 1", state); end
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL seq_lat got %b want 0", if_valid); end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (if_valid !== 1'b1)    begin n_bad++; $display("FAIL seq_valid%0d got %b want 1", i, if_valid); end
         n_cmp++; if (if_pc !== exp_pc[i])   begin n_bad++; $display("FAIL seq_pc%0d got %h want %h", i, if_pc, exp_pc[i]); end
         n_cmp++; if (if_instr !== exp_in[i]) begin n_bad++; $display("FAIL seq_instr%0d got %h want %h", i, if_instr, exp_in[i]); end
         n_cmp++; if (fetch_count !== 32'(i)) begin n_bad++; $display("FAIL seq_count%0d got %0d want %0d", i, fetch_count, i); end
      end
   endtask

   task automatic test_stall();
      // Buffer holds 0xC, pc=0x10, count=3. Re-aim at 0x4 without a handshake.
      if_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h4;
      step();
      redirect_valid = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (if_valid !== 1'b1)        begin n_bad++; $display("FAIL stall_valid%0d got %b want 1", i, if_valid); end
         n_cmp++; if (if_pc !== 32'h4)          begin n_bad++; $display("FAIL stall_pc%0d got %h want 4", i, if_pc); end
         n_cmp++; if (if_instr !== 32'h00400093) begin n_bad++; $display("FAIL stall_instr%0d got %h want 00400093", i, if_instr); end
         n_cmp++; if (imem_address !== 32'h8)   begin n_bad++; $display("FAIL stall_addr%0d got %h want 8", i, imem_address); end
         n_cmp++; if (fetch_count !== 32'd3)    begin n_bad++; $display("FAIL stall_count%0d got %0d want 3", i, fetch_count); end
      end
   endtask

   task automatic test_redirect();
      // Redirect while the 0x4 packet is handshaking: it still counts.
      if_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h14;
      step();
      redirect_valid = 1'b0;
      if_ready = 1'b0;
      n_cmp++; if (if_valid !== 1'b0)       begin n_bad++; $display("FAIL redir_squash got %b want 0", if_valid); end
      n_cmp++; if (if_instr !== NOP)        begin n_bad++; $display("FAIL redir_nop got %h want %h", if_instr, NOP); end
      n_cmp++; if (imem_address !== 32'h14) begin n_bad++; $display("FAIL redir_addr got %h want 14", imem_address); end
      n_cmp++; if (fetch_count !== 32'd4)   begin n_bad++; $display("FAIL redir_count got %0d want 4", fetch_count); end
      step();
      n_cmp++; if (if_valid !== 1'b1)         begin n_bad++; $display("FAIL redir_valid got %b want 1", if_valid); end
      n_cmp++; if (if_pc !== 32'h14)          begin n_bad++; $display("FAIL redir_pc got %h want 14", if_pc); end
      n_cmp++; if (if_instr !== 32'h00008067) begin n_bad++; $display("FAIL redir_instr got %h want 00008067", if_instr); end
   endtask

   task automatic test_drain();
      halt_req = 1'b1;
      step();
      n_cmp++; if (state !== 2'd2)    begin n_bad++; $display("FAIL drain_state got %0d want 2", state); end
      n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid got %b want 1", if_valid); end
      step();
      n_cmp++; if (state !== 2'd2)          begin n_bad++; $display("FAIL drain_hold got %0d want 2", state); end
      n_cmp++; if (if_pc !== 32'h14)        begin n_bad++; $display("FAIL drain_pc got %h want 14", if_pc); end
      n_cmp++; if (imem_address !== 32'h18) begin n_bad++; $display("FAIL drain_addr got %h want 18", imem_address); end
      if_ready = 1'b1;
      step();
      halt_req = 1'b0;
      if_ready = 1'b0;
      n_cmp++; if (state !== 2'd0)        begin n_bad++; $display("FAIL drain_idle got %0d want 0", state); end
      n_cmp++; if (if_valid !== 1'b0)     begin n_bad++; $display("FAIL drain_empty got %b want 0", if_valid); end
      n_cmp++; if (fetch_count !== 32'd5) begin n_bad++; $display("FAIL drain_count got %0d want 5", fetch_count); end
   endtask

   task automatic test_fault_redirect();
      redirect_valid = 1'b1; redirect_pc = 32'h3;
      step();
      redirect_valid = 1'b0;
      n_cmp++; if (state !== 2'd3)     begin n_bad++; $display("FAIL mis_state got %0d want 3", state); end
      n_cmp++; if (fault !== 1'b1)     begin n_bad++; $display("FAIL mis_fault got %b want 1", fault); end
      n_cmp++; if (fault_pc !== 32'h3) begin n_bad++; $display("FAIL mis_fault_pc got %h want 3", fault_pc); end
      n_cmp++; if (if_instr !== NOP)   begin n_bad++; $display("FAIL mis_instr got %h want %h", if_instr, NOP); end
      start = 1'b1;
      step();
      start = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      step();
      redirect_valid = 1'b0;
      n_cmp++; if (state !== 2'd3)     begin n_bad++; $display("FAIL mis_absorb got %0d want 3", state); end
      n_cmp++; if (fault_pc !== 32'h3) begin n_bad++; $display("FAIL mis_sticky got %h want 3", fault_pc); end
      n_cmp++; if (if_valid !== 1'b0)  begin n_bad++; $display("FAIL mis_valid got %b want 0", if_valid); end
   endtask

   task automatic test_range();
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'h1F8;
      step();
      redirect_valid = 1'b0;
      n_cmp++; if (state !== 2'd0)           begin n_bad++; $display("FAIL rng_idle got %0d want 0", state); end
      n_cmp++; if (imem_address !== 32'h1F8) begin n_bad++; $display("FAIL rng_addr got %h want 1f8", imem_address); end
      n_cmp++; if (if_valid !== 1'b0)        begin n_bad++; $display("FAIL rng_nopkt got %b want 0", if_valid); end
      start = 1'b1; if_ready = 1'b1;
      step();
      start = 1'b0;
      step();
      n_cmp++; if (if_pc !== 32'h1F8)        begin n_bad++; $display("FAIL rng_pc0 got %h want 1f8", if_pc); end
      n_cmp++; if (if_instr !== 32'h0000AAAA) begin n_bad++; $display("FAIL rng_in0 got %h want 0000aaaa", if_instr); end
      step();
      n_cmp++; if (if_pc !== 32'h1FC)        begin n_bad++; $display("FAIL rng_pc1 got %h want 1fc", if_pc); end
      n_cmp++; if (if_instr !== 32'h0000BBBB) begin n_bad++; $display("FAIL rng_in1 got %h want 0000bbbb", if_instr); end
      n_cmp++; if (fetch_count !== 32'd1)    begin n_bad++; $display("FAIL rng_cnt1 got %0d want 1", fetch_count); end
      step();
      n_cmp++; if (state !== 2'd3)           begin n_bad++; $display("FAIL rng_state got %0d want 3", state); end
      n_cmp++; if (fault_pc !== 32'h200)     begin n_bad++; $display("FAIL rng_fault_pc got %h want 200", fault_pc); end
      n_cmp++; if (fetch_count !== 32'd2)    begin n_bad++; $display("FAIL rng_cnt2 got %0d want 2", fetch_count); end
      n_cmp++; if (if_valid !== 1'b0)        begin n_bad++; $display("FAIL rng_valid got %b want 0", if_valid); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      if_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %b want 1", if_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (state !== 2'd0)         begin n_bad++; $display("FAIL mid_state got %0d want 0", state); end
      n_cmp++; if (if_valid !== 1'b0)      begin n_bad++; $display("FAIL mid_valid got %b want 0", if_valid); end
      n_cmp++; if (if_pc !== 32'h0)        begin n_bad++; $display("FAIL mid_if_pc got %h want 0", if_pc); end
      n_cmp++; if (if_instr !== NOP)       begin n_bad++; $display("FAIL mid_instr got %h want %h", if_instr, NOP); end
      n_cmp++; if (fetch_count !== 32'h0)  begin n_bad++; $display("FAIL mid_count got %0d want 0", fetch_count); end
      n_cmp++; if (imem_address !== 32'h0) begin n_bad++; $display("FAIL mid_addr got %h want 0", imem_address); end
      n_cmp++; if (fault !== 1'b0)         begin n_bad++; $display("FAIL mid_fault got %b want 0", fault); end
      if_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = NOP;
      mem[0] = 32'h00000013; mem[1] = 32'h00400093; mem[2] = 32'h00C00113;
      mem[3] = 32'h002081B3; mem[4] = 32'h00312023; mem[5] = 32'h00008067;
      mem[126] = 32'h0000AAAA; mem[127] = 32'h0000BBBB;

      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_drain();
      test_fault_redirect();
      test_range();
      test_reset_mid_run();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
